// File: rtl/history_controller.sv
// Sequencer for the UART byte history buffer: pushes received bytes with a clean
// single-cycle shift strobe, issues clears, and replays stored bytes oldest-first.
module history_controller #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rxValid,
  input  logic [DW-1:0]       rxData,
  input  logic                clrReq,
  input  logic                replayReq,
  input  logic [DEPTH*DW-1:0] memData,
  output logic [DW-1:0]       memDataIn,
  output logic                shift,
  output logic                clr,
  output logic [DW-1:0]       txData,
  output logic                txValid,
  input  logic                txReady,
  output logic                rxDrop,
  output logic [2:0]          count,
  output logic                busy
);

  localparam int          IW      = $clog2(DEPTH);
  localparam logic [2:0]  DEPTH_C = 3'(DEPTH);

  typedef enum logic [2:0] {
    CLEAR  = 3'd0,
    IDLE   = 3'd1,
    SETUP  = 3'd2,
    STROBE = 3'd3,
    LOAD   = 3'd4,
    WAIT   = 3'd5
  } state_t;

  state_t          state, state_nxt;
  logic            clrPending, pend_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  logic [DW-1:0]   mdi_nxt, txd_nxt;
  logic            shift_nxt, clr_nxt, txv_nxt, drop_nxt;
  logic [2:0]      cnt_nxt;
  logic [DW-1:0]   ent [DEPTH];

  function automatic logic [2:0] sat_inc(input logic [2:0] c);
    return (c >= DEPTH_C) ? DEPTH_C : c + 3'd1;
  endfunction

  always_comb begin
    for (int k = 0; k < DEPTH; k++) ent[k] = memData[k*DW +: DW];
  end

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    clr_nxt   = clr;
    shift_nxt = shift;
    mdi_nxt   = memDataIn;
    txd_nxt   = txData;
    txv_nxt   = txValid;
    cnt_nxt   = count;
    idx_nxt   = idx;
    pend_nxt  = clrPending;
    drop_nxt  = 1'b0;
    // Anything arriving while we are occupied is either dropped or deferred.
    if (state != IDLE) begin
      drop_nxt = rxValid;
      if (clrReq) pend_nxt = 1'b1;
    end
    case (state)
      CLEAR: begin
        clr_nxt   = 1'b0;
        cnt_nxt   = 3'd0;
        state_nxt = IDLE;
      end
      IDLE: begin
        if (clrPending || clrReq) begin
          clr_nxt   = 1'b1;
          pend_nxt  = 1'b0;
          drop_nxt  = rxValid;
          state_nxt = CLEAR;
        end else if (rxValid) begin
          mdi_nxt   = rxData;
          state_nxt = SETUP;
        end else if (replayReq && count != 3'd0) begin
          idx_nxt   = IW'(count - 3'd1);
          state_nxt = LOAD;
        end
      end
      SETUP: begin
        shift_nxt = 1'b1;
        cnt_nxt   = sat_inc(count);
        state_nxt = STROBE;
      end
      STROBE: begin
        shift_nxt = 1'b0;
        state_nxt = IDLE;
      end
      LOAD: begin
        txd_nxt   = ent[idx];
        txv_nxt   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (txValid && txReady) begin
          txv_nxt = 1'b0;
          if (idx == '0) begin
            state_nxt = IDLE;
          end else begin
            idx_nxt   = idx - IW'(1);
            state_nxt = LOAD;
          end
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR;
      clr        <= 1'b1;
      count      <= 3'd0;
      shift      <= 1'b0;
      memDataIn  <= '0;
      txData     <= '0;
      txValid    <= 1'b0;
      rxDrop     <= 1'b0;
      clrPending <= 1'b0;
      idx        <= '0;
    end else begin
      state      <= state_nxt;
      clr        <= clr_nxt;
      count      <= cnt_nxt;
      shift      <= shift_nxt;
      memDataIn  <= mdi_nxt;
      txData     <= txd_nxt;
      txValid    <= txv_nxt;
      rxDrop     <= drop_nxt;
      clrPending <= pend_nxt;
      idx        <= idx_nxt;
    end
  end

endmodule
